// File: rtl/pwm_capture_pkg.sv
// Shared defaults and FSM encoding for the PWM capture block.
package pwm_capture_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned TIMEOUT_DEF = 20000;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_e;

endpackage

// File: rtl/pwm_edge_sync.sv
// Two-flop synchronizer plus history flop; registered single-cycle rise/fall pulses.
module pwm_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist;
    logic r_rise;
    logic r_fall;

    // Level output is the history flop so it lines up with the edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_sync1 <= i_async;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_rise  <= r_sync2 & ~r_hist;
            r_fall  <= ~r_sync2 & r_hist;
        end
    end

    assign o_lvl  = r_hist;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/pwm_capture.sv
// Measures period (rise to rise) and high time (rise to fall) of a PWM input in clk
// cycles, and flags a stuck input when no rising edge arrives within TIMEOUT cycles.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TO_M1  = CNT_W'(TIMEOUT - 1);

    logic             w_lvl;
    logic             w_rise;
    logic             w_fall;
    state_e           r_state;
    state_e           w_state_nxt;
    logic             w_capture;
    logic             w_timeout;
    logic             w_arm;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_lat;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_valid;
    logic             r_stuck;
    logic             r_stuck_level;

    pwm_edge_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .i_async(pwm_in),
        .o_lvl  (w_lvl),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Timeout fires one cycle early so stuck asserts as cnt reaches TIMEOUT.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_arm       = 1'b0;
        if (!en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_MEASURE;
                        w_arm       = 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (w_rise) begin
                        w_capture = 1'b1;
                    end else if (r_cnt >= TO_M1) begin
                        w_state_nxt = ST_IDLE;
                        w_timeout   = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_hi_lat      <= '0;
            r_period      <= '0;
            r_high_time   <= '0;
            r_valid       <= 1'b0;
            r_stuck       <= 1'b0;
            r_stuck_level <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (!en) begin
                r_cnt   <= '0;
                r_stuck <= 1'b0;
            end else begin
                if (w_rise) begin
                    r_cnt <= CNT_W'(1);
                end else if (r_cnt < TO_VAL) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_fall && (r_state == ST_MEASURE)) begin
                    r_hi_lat <= r_cnt;
                end
                if (w_capture) begin
                    r_period    <= r_cnt;
                    r_high_time <= r_hi_lat;
                end
                if (w_timeout) begin
                    r_stuck       <= 1'b1;
                    r_stuck_level <= w_lvl;
                end else if (w_arm) begin
                    r_stuck <= 1'b0;
                end
            end
        end
    end

    assign period      = r_period;
    assign high_time   = r_high_time;
    assign valid       = r_valid;
    assign stuck       = r_stuck;
    assign stuck_level = r_stuck_level;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: pin-level waveform generator with a period/high-time scoreboard.
module tb_pwm_capture;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 20000;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             stuck;
    logic             stuck_level;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pwm_in     (pwm_in),
        .period     (period),
        .high_time  (high_time),
        .valid      (valid),
        .stuck      (stuck),
        .stuck_level(stuck_level)
    );

    int          n_pass;
    int          n_fail;
    logic [31:0] exp_q[$];
    bit          armed;
    logic        prev_pin;
    int          since_rise;
    int          high_cnt;
    int          h_lat;

    // One clock of stimulus: score any valid seen, then drive the next pin level.
    task automatic step(input logic v);
        logic [31:0] e;
        @(negedge clk);
        if (valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: got period=%0d high=%0d, required no valid",
                         period, high_time);
            end else begin
                e = exp_q.pop_front();
                if (period !== e[31:16] || high_time !== e[15:0]) begin
                    n_fail++;
                    $display("FAIL measurement: got %0d/%0d, required %0d/%0d",
                             period, high_time, e[31:16], e[15:0]);
                end else begin
                    n_pass++;
                end
            end
        end
        if (v && !prev_pin) begin
            if (armed) exp_q.push_back({16'(since_rise), 16'(h_lat)});
            armed      = (en === 1'b1);
            since_rise = 1;
            high_cnt   = 1;
        end else begin
            since_rise++;
            if (v) high_cnt++;
            if (!v && prev_pin) h_lat = high_cnt;
        end
        pwm_in   = v;
        prev_pin = v;
    endtask

    task automatic pulse(input int p, input int h);
        for (int i = 0; i < h; i++) step(1'b1);
        for (int i = 0; i < p - h; i++) step(1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b0;
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", valid); end else n_pass++;
        if (stuck !== 1'b0) begin n_fail++; $display("FAIL reset_stuck: got %b, required 0", stuck); end else n_pass++;
        if (stuck_level !== 1'b0) begin n_fail++; $display("FAIL reset_stuck_level: got %b, required 0", stuck_level); end else n_pass++;
        if (period !== 16'd0) begin n_fail++; $display("FAIL reset_period: got %0d, required 0", period); end else n_pass++;
        if (high_time !== 16'd0) begin n_fail++; $display("FAIL reset_high: got %0d, required 0", high_time); end else n_pass++;
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_idle_low;
        repeat (TIMEOUT + 20) step(1'b0);
        if (stuck !== 1'b0) begin n_fail++; $display("FAIL idle_low_stuck: got %b, required 0", stuck); end else n_pass++;
        if (period !== 16'd0) begin n_fail++; $display("FAIL idle_low_period: got %0d, required 0", period); end else n_pass++;
    endtask

    task automatic test_basic;
        repeat (6) pulse(100, 30);
        repeat (8) step(prev_pin);
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL basic_missing_valid: got %0d pending, required 0", exp_q.size()); end else n_pass++;
        if (period !== 16'd100 || high_time !== 16'd30) begin
            n_fail++; $display("FAIL basic_final: got %0d/%0d, required 100/30", period, high_time);
        end else n_pass++;
    endtask

    task automatic test_change;
        repeat (3) pulse(250, 200);
        repeat (8) step(prev_pin);
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL change_missing_valid: got %0d pending, required 0", exp_q.size()); end else n_pass++;
        if (period !== 16'd250 || high_time !== 16'd200) begin
            n_fail++; $display("FAIL change_final: got %0d/%0d, required 250/200", period, high_time);
        end else n_pass++;
    endtask

    // Stop toggling after a rise; stuck must appear exactly TIMEOUT clocks after the synced rise.
    task automatic test_stuck(input logic lvl);
        repeat (2) pulse(100, 30);
        step(1'b1);
        for (int i = 1; i <= int'(TIMEOUT) + 3; i++) begin
            step(lvl | (i < 30));
            if (i == int'(TIMEOUT) + 2 && stuck !== 1'b0) begin
                n_fail++; $display("FAIL stuck_early lvl=%b: got %b, required 0", lvl, stuck);
            end else if (i == int'(TIMEOUT) + 2) n_pass++;
        end
        if (stuck !== 1'b1 || stuck_level !== lvl) begin
            n_fail++; $display("FAIL stuck_assert: got stuck=%b level=%b, required 1/%b", stuck, stuck_level, lvl);
        end else n_pass++;
        if (period !== 16'd100 || high_time !== 16'd30) begin
            n_fail++; $display("FAIL stuck_hold: got %0d/%0d, required 100/30", period, high_time);
        end else n_pass++;
        armed = 1'b0;
        repeat (10) step(1'b0);
        if (stuck !== 1'b1) begin n_fail++; $display("FAIL stuck_sticky: got %b, required 1", stuck); end else n_pass++;
        repeat (6) step(1'b1);
        if (stuck !== 1'b0) begin n_fail++; $display("FAIL stuck_clear: got %b, required 0", stuck); end else n_pass++;
        repeat (70) step(1'b0);
        repeat (3) pulse(50, 10);
        repeat (8) step(prev_pin);
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL stuck_recover: got %0d pending, required 0", exp_q.size()); end else n_pass++;
    endtask

    task automatic test_enable;
        repeat (2) pulse(100, 30);
        en    = 1'b0;
        armed = 1'b0;
        repeat (3) pulse(60, 20);
        if (stuck !== 1'b0) begin n_fail++; $display("FAIL en_off_stuck: got %b, required 0", stuck); end else n_pass++;
        if (period !== 16'd100 || high_time !== 16'd30) begin
            n_fail++; $display("FAIL en_off_hold: got %0d/%0d, required 100/30", period, high_time);
        end else n_pass++;
        en = 1'b1;
        repeat (3) pulse(60, 20);
        repeat (8) step(prev_pin);
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL en_resume: got %0d pending, required 0", exp_q.size()); end else n_pass++;
        if (period !== 16'd60 || high_time !== 16'd20) begin
            n_fail++; $display("FAIL en_resume_value: got %0d/%0d, required 60/20", period, high_time);
        end else n_pass++;
    endtask

    task automatic test_min_pulse;
        repeat (10) pulse(3, 1);
        repeat (8) step(prev_pin);
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL min_missing_valid: got %0d pending, required 0", exp_q.size()); end else n_pass++;
        if (period !== 16'd3 || high_time !== 16'd1) begin
            n_fail++; $display("FAIL min_final: got %0d/%0d, required 3/1", period, high_time);
        end else n_pass++;
    endtask

    // Asynchronous reset in a low phase; the first valid must need two fresh rises.
    task automatic test_reset_mid;
        repeat (2) pulse(100, 30);
        repeat (30) step(1'b1);
        repeat (20) step(1'b0);
        #2 rst = 1'b1;
        #1;
        if (valid !== 1'b0 || stuck !== 1'b0 || stuck_level !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_flags: got v=%b s=%b l=%b, required 0/0/0", valid, stuck, stuck_level);
        end else n_pass++;
        if (period !== 16'd0 || high_time !== 16'd0) begin
            n_fail++; $display("FAIL rst_mid_values: got %0d/%0d, required 0/0", period, high_time);
        end else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        armed = 1'b0;
        repeat (3) pulse(100, 30);
        repeat (8) step(prev_pin);
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_resume: got %0d pending, required 0", exp_q.size()); end else n_pass++;
        if (period !== 16'd100 || high_time !== 16'd30) begin
            n_fail++; $display("FAIL rst_mid_value: got %0d/%0d, required 100/30", period, high_time);
        end else n_pass++;
    endtask

    initial begin
        n_pass     = 0;
        n_fail     = 0;
        armed      = 1'b0;
        prev_pin   = 1'b0;
        since_rise = 0;
        high_cnt   = 0;
        h_lat      = 0;
        test_reset();
        test_idle_low();
        test_basic();
        test_change();
        test_stuck(1'b1);
        test_stuck(1'b0);
        test_enable();
        test_min_pulse();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
